buffer_access_arbiter: RTL and testbench
========================================

Name: buffer_access_arbiter

Overview:
- Sequences all accesses to the receiver/transmitter 64-byte single-port data buffer and shares it between two requesters: the USB side (RX byte stores, TX byte fetches) and the host/AHB side.
- Owns the FIFO read/write pointers and the buffer_occupancy count consumed by the rx_data_ready and tx status logic.
- Performs at most one memory access per cycle.

Parameters:
- DEPTH, 64, number of buffer entries; must be a power of two.
- ADDR_W, 6, log2(DEPTH).
- DATA_W, 8, byte width.

Ports:
- clk  in  1  clock
- n_rst  in  1  asynchronous active-low reset
- flush  in  1  clear buffer: pointers and occupancy go to 0
- usb_busy  in  1  USB packet in progress; USB gets strict priority
- usb_wr_req  in  1  USB store request
- usb_wr_data  in  DATA_W  USB store byte
- usb_rd_req  in  1  USB fetch request
- usb_gnt  out  1  USB request accepted this cycle
- host_wr_req  in  1  host store request
- host_wr_data  in  DATA_W  host store byte
- host_rd_req  in  1  host fetch request
- host_gnt  out  1  host request accepted this cycle
- rd_data  out  DATA_W  fetched byte (mem_rdata passthrough)
- usb_rd_valid  out  1  rd_data belongs to USB this cycle
- host_rd_valid  out  1  rd_data belongs to host this cycle
- mem_en  out  1  buffer access strobe
- mem_we  out  1  1 = write, 0 = read
- mem_addr  out  ADDR_W  buffer address
- mem_wdata  out  DATA_W  write byte
- mem_rdata  in  DATA_W  read byte, valid one cycle after a read access
- buffer_occupancy  out  ADDR_W+1  entries held, 0..DEPTH
- overflow_err  out  1  one-cycle pulse: write refused, buffer full
- underrun_err  out  1  one-cycle pulse: read refused, buffer empty

Behaviour:
- Reset: wr_ptr = 0, rd_ptr = 0, occupancy = 0, last_winner = HOST, state = ARB_SHARED. All outputs are 0.
- Requester request: a requester's request = wr_req | rd_req. If both are set, the write is serviced first and the read stays pending.
- Eligibility: a write is eligible only if occupancy < DEPTH; a read is eligible only if occupancy > 0.
- Ineligible requests:
  - An ineligible request is never granted.
  - An ineligible write pulses overflow_err; an ineligible read pulses underrun_err. These pulses are registered and appear the cycle after the refused request.
  - The error repeats every cycle the request is held.
- FSM states:
  - ARB_SHARED: round-robin. When both requesters are eligible, the winner is the one not in last_winner. A lone eligible requester wins.
  - ARB_USB_LOCK: only USB can be granted. The host waits; no error is raised for a waiting host.
  - ARB_SHARED -> ARB_USB_LOCK when usb_busy = 1. ARB_USB_LOCK -> ARB_SHARED when usb_busy = 0. The transition is registered; the state is sampled at the clock edge.
- Grant timing:
  - Grants are combinational in the request cycle; the requester holds its request and data until it sees its gnt.
  - mem_en, mem_we, mem_addr and mem_wdata are driven combinationally from the winning access.
  - Write address = wr_ptr; read address = rd_ptr.
- Updates on the grant edge:
  - A granted write increments wr_ptr and adds 1 to occupancy.
  - A granted read increments rd_ptr and subtracts 1 from occupancy.
  - Pointers wrap modulo DEPTH (63 -> 0). Only one access per cycle, so occupancy never sees a simultaneous increment and decrement.
- Update last_winner on every grant, in either state.
- Read latency: rd_data = mem_rdata in the cycle after a read grant. Exactly one of usb_rd_valid or host_rd_valid pulses in that cycle, per the registered owner tag. Back-to-back read grants give one byte per cycle.
- Flush:
  - flush has top priority: no grant and no mem_en in that cycle.
  - On the next edge, pointers and occupancy go to 0.
  - A read valid already in flight still presents its byte.
  - Error pulses are suppressed during flush.
- Reset mid-operation: all registers return to their reset values immediately. Any pending read valid is dropped.

Decomposition:
- Shared package buffer_pkg holds:
  - DEPTH, ADDR_W and DATA_W defaults;
  - the enum arb_state_t {ARB_SHARED, ARB_USB_LOCK};
  - the enum requester_t {REQ_USB, REQ_HOST}.
- One natural sub-module: fifo_ptr_ctrl. It contains wr_ptr, rd_ptr and the occupancy counter, with inputs wr_inc, rd_inc and flush, and outputs the pointers, occupancy, full and empty. The arbiter FSM and the mem mux stay in the top module.

Test Plan:
- Reset, then USB writes 0xA5, then host reads -> usb_gnt in the write cycle; mem_addr = 0, occupancy = 1; host_gnt with mem_addr = 0; next cycle rd_data = 0xA5, host_rd_valid = 1, occupancy = 0.
- Both requesters hold writes for 4 cycles from reset -> grants alternate USB, host, USB, host; occupancy = 4; wr_ptr = 4.
- usb_busy = 1 and the host holds a read for 5 cycles while USB writes every cycle -> host_gnt stays 0 and no underrun_err; after usb_busy falls, host_gnt asserts the cycle after ARB_SHARED is entered.
- Fill with 64 USB writes, then a 65th write -> occupancy = 64, no usb_gnt, overflow_err pulses the next cycle; then 64 reads drain to 0 and wr_ptr wraps to 0.
- Read on an empty buffer -> no grant, underrun_err = 1 next cycle, no mem_en.
- With occupancy = 10, assert flush together with host_rd_req -> no grant; next cycle occupancy = 0 and both pointers = 0; no error pulse.

Source files
------------

// File: rtl/buffer_pkg.sv
// Shared types and default sizing for the RX/TX data buffer arbiter.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package buffer_pkg;

    localparam int BUF_DEPTH  = 64;
    localparam int BUF_ADDR_W = 6;
    localparam int BUF_DATA_W = 8;

    typedef enum logic {
        ARB_SHARED   = 1'b0,
        ARB_USB_LOCK = 1'b1
    } arb_state_t;

    typedef enum logic {
        REQ_USB  = 1'b0,
        REQ_HOST = 1'b1
    } requester_t;

endpackage

// File: rtl/fifo_ptr_ctrl.sv
// Circular-buffer bookkeeping: write/read pointers and occupancy count.
// Latency: pointers and count update on the edge after wr_inc/rd_inc/flush.
// Backpressure: none; the caller never asserts wr_inc when full or rd_inc when empty.
module fifo_ptr_ctrl #(
    parameter int DEPTH  = 64,
    parameter int ADDR_W = 6
) (
    input  logic              clk,
    input  logic              n_rst,
    input  logic              wr_inc,
    input  logic              rd_inc,
    input  logic              flush,
    output logic [ADDR_W-1:0] wr_ptr,
    output logic [ADDR_W-1:0] rd_ptr,
    output logic [ADDR_W:0]   occupancy,
    output logic              full,
    output logic              empty
);

    localparam logic [ADDR_W:0]   FULL_CNT = (ADDR_W+1)'(DEPTH);
    localparam logic [ADDR_W-1:0] PTR_ONE  = 1;
    localparam logic [ADDR_W:0]   OCC_ONE  = 1;

    logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [ADDR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [ADDR_W:0]   occ_q, occ_d;

    // Next pointer/count; flush wins, and write and read are mutually exclusive
    // because only one buffer access happens per cycle. Pointers wrap naturally.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        occ_d    = occ_q;
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            occ_d    = '0;
        end else if (wr_inc) begin
            wr_ptr_d = wr_ptr_q + PTR_ONE;
            occ_d    = occ_q + OCC_ONE;
        end else if (rd_inc) begin
            rd_ptr_d = rd_ptr_q + PTR_ONE;
            occ_d    = occ_q - OCC_ONE;
        end
    end

    // Pointer and occupancy registers.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            occ_q    <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            occ_q    <= occ_d;
        end
    end

    assign wr_ptr    = wr_ptr_q;
    assign rd_ptr    = rd_ptr_q;
    assign occupancy = occ_q;
    assign full      = (occ_q == FULL_CNT);
    assign empty     = (occ_q == '0);

endmodule

// File: rtl/buffer_access_arbiter.sv
// Shares the single-port RX/TX byte buffer between the USB side and the host side.
// Latency: grant and memory strobe combinational; read data and errors one cycle later.
// Backpressure: requesters hold request/data until their gnt; USB locks out host while busy.
module buffer_access_arbiter
    import buffer_pkg::*;
#(
    parameter int DEPTH  = BUF_DEPTH,
    parameter int ADDR_W = BUF_ADDR_W,
    parameter int DATA_W = BUF_DATA_W
) (
    input  logic              clk,
    input  logic              n_rst,
    input  logic              flush,
    input  logic              usb_busy,
    input  logic              usb_wr_req,
    input  logic [DATA_W-1:0] usb_wr_data,
    input  logic              usb_rd_req,
    output logic              usb_gnt,
    input  logic              host_wr_req,
    input  logic [DATA_W-1:0] host_wr_data,
    input  logic              host_rd_req,
    output logic              host_gnt,
    output logic [DATA_W-1:0] rd_data,
    output logic              usb_rd_valid,
    output logic              host_rd_valid,
    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic [ADDR_W:0]   buffer_occupancy,
    output logic              overflow_err,
    output logic              underrun_err
);

    arb_state_t state_q, state_d;
    requester_t last_q, last_d;
    requester_t rd_owner_q, rd_owner_d;
    logic       rd_vld_q, rd_vld_d;
    logic       ovf_q, ovf_d;
    logic       und_q, und_d;

    logic              usb_elig, host_elig, host_active;
    logic              wr_inc, rd_inc;
    logic              full, empty;
    logic [ADDR_W-1:0] wr_ptr, rd_ptr;

    fifo_ptr_ctrl #(
        .DEPTH  (DEPTH),
        .ADDR_W (ADDR_W)
    ) u_ptr (
        .clk       (clk),
        .n_rst     (n_rst),
        .wr_inc    (wr_inc),
        .rd_inc    (rd_inc),
        .flush     (flush),
        .wr_ptr    (wr_ptr),
        .rd_ptr    (rd_ptr),
        .occupancy (buffer_occupancy),
        .full      (full),
        .empty     (empty)
    );

    // Arbitration: a pending write shadows a pending read from the same side;
    // the host is ignored entirely while USB holds the lock.
    always_comb begin
        usb_gnt     = 1'b0;
        host_gnt    = 1'b0;
        host_active = (state_q == ARB_SHARED);
        usb_elig    = usb_wr_req ? !full : (usb_rd_req && !empty);
        host_elig   = host_active && (host_wr_req ? !full : (host_rd_req && !empty));
        if (!flush) begin
            if (usb_elig && host_elig) begin
                usb_gnt  = (last_q == REQ_HOST);
                host_gnt = (last_q == REQ_USB);
            end else begin
                usb_gnt  = usb_elig;
                host_gnt = host_elig;
            end
        end
    end

    // Memory port mux driven by the winning access.
    always_comb begin
        mem_en    = 1'b0;
        mem_we    = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        if (usb_gnt) begin
            mem_en    = 1'b1;
            mem_we    = usb_wr_req;
            mem_addr  = usb_wr_req ? wr_ptr : rd_ptr;
            mem_wdata = usb_wr_req ? usb_wr_data : '0;
        end else if (host_gnt) begin
            mem_en    = 1'b1;
            mem_we    = host_wr_req;
            mem_addr  = host_wr_req ? wr_ptr : rd_ptr;
            mem_wdata = host_wr_req ? host_wr_data : '0;
        end
        wr_inc = mem_en && mem_we;
        rd_inc = mem_en && !mem_we;
    end

    // Next state, round-robin history, read-owner tag and refused-access errors.
    always_comb begin
        state_d    = usb_busy ? ARB_USB_LOCK : ARB_SHARED;
        last_d     = last_q;
        rd_vld_d   = rd_inc;
        rd_owner_d = rd_owner_q;
        if (usb_gnt) begin
            last_d = REQ_USB;
        end else if (host_gnt) begin
            last_d = REQ_HOST;
        end
        if (rd_inc) begin
            rd_owner_d = host_gnt ? REQ_HOST : REQ_USB;
        end
        ovf_d = !flush && full &&
                (usb_wr_req || (host_active && host_wr_req));
        und_d = !flush && empty &&
                ((usb_rd_req && !usb_wr_req) ||
                 (host_active && host_rd_req && !host_wr_req));
    end

    // Arbiter state registers.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state_q    <= ARB_SHARED;
            last_q     <= REQ_HOST;
            rd_owner_q <= REQ_USB;
            rd_vld_q   <= 1'b0;
            ovf_q      <= 1'b0;
            und_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            last_q     <= last_d;
            rd_owner_q <= rd_owner_d;
            rd_vld_q   <= rd_vld_d;
            ovf_q      <= ovf_d;
            und_q      <= und_d;
        end
    end

    assign usb_rd_valid  = rd_vld_q && (rd_owner_q == REQ_USB);
    assign host_rd_valid = rd_vld_q && (rd_owner_q == REQ_HOST);
    assign rd_data       = rd_vld_q ? mem_rdata : '0;
    assign overflow_err  = ovf_q;
    assign underrun_err  = und_q;

endmodule

// File: tb/tb_buffer_access_arbiter.sv
module tb_buffer_access_arbiter;

    localparam int DEPTH = 64;

    logic       clk, n_rst;
    logic       flush, usb_busy;
    logic       usb_wr_req, usb_rd_req, host_wr_req, host_rd_req;
    logic [7:0] usb_wr_data, host_wr_data;
    logic       usb_gnt, host_gnt, usb_rd_valid, host_rd_valid;
    logic       mem_en, mem_we, overflow_err, underrun_err;
    logic [5:0] mem_addr;
    logic [7:0] mem_wdata, mem_rdata, rd_data;
    logic [6:0] buffer_occupancy;

    buffer_access_arbiter dut (
        .clk              (clk),
        .n_rst            (n_rst),
        .flush            (flush),
        .usb_busy         (usb_busy),
        .usb_wr_req       (usb_wr_req),
        .usb_wr_data      (usb_wr_data),
        .usb_rd_req       (usb_rd_req),
        .usb_gnt          (usb_gnt),
        .host_wr_req      (host_wr_req),
        .host_wr_data     (host_wr_data),
        .host_rd_req      (host_rd_req),
        .host_gnt         (host_gnt),
        .rd_data          (rd_data),
        .usb_rd_valid     (usb_rd_valid),
        .host_rd_valid    (host_rd_valid),
        .mem_en           (mem_en),
        .mem_we           (mem_we),
        .mem_addr         (mem_addr),
        .mem_wdata        (mem_wdata),
        .mem_rdata        (mem_rdata),
        .buffer_occupancy (buffer_occupancy),
        .overflow_err     (overflow_err),
        .underrun_err     (underrun_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Single-port buffer RAM with one-cycle read latency.
    logic [7:0] mem [DEPTH];
    always @(posedge clk) begin
        if (mem_en) begin
            if (mem_we) mem[mem_addr] <= mem_wdata;
            else        mem_rdata     <= mem[mem_addr];
        end
    end

    int n_checks = 0;
    int n_errs   = 0;

    // Reference model: the buffer contents as a byte queue plus plain counters.
    logic [7:0] fifo_q[$];
    int         wr_cnt, rd_cnt;
    bit         locked, last_host;
    bit         pend_vld, pend_host;
    logic [7:0] pend_data;
    bit         exp_ovf, exp_und;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errs++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic model_reset();
        fifo_q.delete();
        wr_cnt = 0; rd_cnt = 0;
        locked = 0; last_host = 1;
        pend_vld = 0; pend_host = 0; pend_data = 8'h00;
        exp_ovf = 0; exp_und = 0;
    endtask

    task automatic drive_idle();
        flush = 0; usb_busy = 0;
        usb_wr_req = 0; usb_rd_req = 0; usb_wr_data = 8'h00;
        host_wr_req = 0; host_rd_req = 0; host_wr_data = 8'h00;
    endtask

    task automatic check_all_zero(input string tag);
        chk({tag, "_usb_gnt"}, usb_gnt, 0);
        chk({tag, "_host_gnt"}, host_gnt, 0);
        chk({tag, "_mem_en"}, mem_en, 0);
        chk({tag, "_mem_we"}, mem_we, 0);
        chk({tag, "_mem_addr"}, mem_addr, 0);
        chk({tag, "_mem_wdata"}, mem_wdata, 0);
        chk({tag, "_rd_data"}, rd_data, 0);
        chk({tag, "_usb_rd_valid"}, usb_rd_valid, 0);
        chk({tag, "_host_rd_valid"}, host_rd_valid, 0);
        chk({tag, "_occupancy"}, buffer_occupancy, 0);
        chk({tag, "_ovf"}, overflow_err, 0);
        chk({tag, "_und"}, underrun_err, 0);
    endtask

    task automatic do_reset(input string tag);
        @(negedge clk);
        drive_idle();
        n_rst = 0;
        #1;
        check_all_zero(tag);
        model_reset();
        @(negedge clk);
        n_rst = 1;
    endtask

    // One bus cycle: drive inputs, compare against the model, advance the model.
    task automatic step(input bit uw, input bit ur, input logic [7:0] ud,
                        input bit hw, input bit hr, input logic [7:0] hd,
                        input bit busy, input bit fl);
        int  occ;
        bit  u_ok, h_ok, gu, gh, g_wr;
        @(negedge clk);
        usb_wr_req = uw; usb_rd_req = ur; usb_wr_data = ud;
        host_wr_req = hw; host_rd_req = hr; host_wr_data = hd;
        usb_busy = busy; flush = fl;
        #1;
        chk("usb_rd_valid", usb_rd_valid, pend_vld && !pend_host);
        chk("host_rd_valid", host_rd_valid, pend_vld && pend_host);
        chk("rd_data", rd_data, pend_vld ? pend_data : 8'h00);
        chk("occupancy", buffer_occupancy, fifo_q.size());
        chk("overflow_err", overflow_err, exp_ovf);
        chk("underrun_err", underrun_err, exp_und);

        occ  = fifo_q.size();
        u_ok = uw ? (occ < DEPTH) : (ur && occ > 0);
        h_ok = !locked && (hw ? (occ < DEPTH) : (hr && occ > 0));
        gu = 0; gh = 0;
        if (!fl) begin
            if (u_ok && h_ok) begin
                gu = last_host;
                gh = !last_host;
            end else begin
                gu = u_ok;
                gh = h_ok;
            end
        end
        g_wr = (gu && uw) || (gh && hw);
        chk("usb_gnt", usb_gnt, gu);
        chk("host_gnt", host_gnt, gh);
        chk("mem_en", mem_en, gu || gh);
        chk("mem_we", mem_we, g_wr);
        if (gu || gh) chk("mem_addr", mem_addr, g_wr ? (wr_cnt % DEPTH) : (rd_cnt % DEPTH));
        if (g_wr) chk("mem_wdata", mem_wdata, gu ? ud : hd);

        pend_vld = 0;
        if (g_wr) begin
            fifo_q.push_back(gu ? ud : hd);
            wr_cnt++;
        end else if (gu || gh) begin
            pend_vld  = 1;
            pend_host = gh;
            pend_data = fifo_q.pop_front();
            rd_cnt++;
        end
        if (gu || gh) last_host = gh;
        exp_ovf = !fl && occ == DEPTH && (uw || (!locked && hw));
        exp_und = !fl && occ == 0 && ((ur && !uw) || (!locked && hr && !hw));
        if (fl) begin
            fifo_q.delete();
            wr_cnt = 0; rd_cnt = 0;
        end
        locked = busy;
    endtask

    initial begin
        bit busy_r;
        int pw, pr;
        n_rst = 0;
        drive_idle();
        model_reset();
        do_reset("reset");

        // USB stores 0xA5, host fetches it back.
        step(1, 0, 8'hA5, 0, 0, 8'h00, 0, 0);
        step(0, 0, 8'h00, 0, 1, 8'h00, 0, 0);
        step(0, 0, 8'h00, 0, 0, 8'h00, 0, 0);

        // Both sides writing: grants alternate.
        for (int i = 0; i < 4; i++) step(1, 0, 8'h10 + 8'(i), 1, 0, 8'h20 + 8'(i), 0, 0);

        // USB lock: host read waits silently, then gets in once shared again.
        for (int i = 0; i < 6; i++) step(1, 0, 8'h30 + 8'(i), 0, 1, 8'h00, 1, 0);
        for (int i = 0; i < 3; i++) step(1, 0, 8'h40 + 8'(i), 0, 1, 8'h00, 0, 0);

        // Fill to full, refused write, drain to empty, refused read.
        step(0, 0, 8'h00, 0, 0, 8'h00, 0, 1);
        for (int i = 0; i < DEPTH; i++) step(1, 0, 8'($urandom), 0, 0, 8'h00, 0, 0);
        step(1, 0, 8'hEE, 0, 0, 8'h00, 0, 0);
        step(1, 0, 8'hEF, 0, 0, 8'h00, 0, 0);
        for (int i = 0; i < DEPTH; i++) step(0, 0, 8'h00, 0, 1, 8'h00, 0, 0);
        step(0, 0, 8'h00, 0, 1, 8'h00, 0, 0);
        step(0, 1, 8'h00, 0, 0, 8'h00, 0, 0);
        step(0, 0, 8'h00, 0, 0, 8'h00, 0, 0);

        // Flush with a read pending at occupancy 10.
        for (int i = 0; i < 10; i++) step(0, 0, 8'h00, 1, 0, 8'h50 + 8'(i), 0, 0);
        step(0, 0, 8'h00, 0, 1, 8'h00, 0, 0);
        step(0, 0, 8'h00, 0, 1, 8'h00, 0, 1);
        step(0, 0, 8'h00, 0, 0, 8'h00, 0, 0);

        // Randomized traffic with write-heavy, balanced and read-heavy phases.
        busy_r = 0;
        for (int i = 0; i < 3000; i++) begin
            case ((i / 300) % 3)
                0:       begin pw = 70; pr = 20; end
                1:       begin pw = 40; pr = 40; end
                default: begin pw = 15; pr = 70; end
            endcase
            if ($urandom_range(0, 99) < 6) busy_r = !busy_r;
            step($urandom_range(0, 99) < pw, $urandom_range(0, 99) < pr, 8'($urandom),
                 $urandom_range(0, 99) < pw, $urandom_range(0, 99) < pr, 8'($urandom),
                 busy_r, $urandom_range(0, 199) == 0);
        end

        // Reset while a read is in flight drops the pending valid.
        step(0, 0, 8'h00, 0, 0, 8'h00, 0, 1);
        step(1, 0, 8'h77, 0, 0, 8'h00, 0, 0);
        step(0, 0, 8'h00, 0, 1, 8'h00, 0, 0);
        do_reset("midreset");
        step(0, 0, 8'h00, 0, 0, 8'h00, 0, 0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errs);
        $finish;
    end

endmodule
